shift_engine: RTL and testbench
===============================

// Module: shift_engine
// PURPOSE
//  Multi-cycle, parametrised ARM operand-2 shifter with valid/ready handshakes.
//  Supports LSL/LSR/ASR/ROR/RRX with ARM register-specified amount semantics and carry-out.
//  Shifts up to STEP bit positions per cycle, so wide shifts cost more cycles than a full barrel.
//  Sits between register read and the ALU in the datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  STEP   8   max bit positions shifted per cycle; power of two, 1..WIDTH
//  AMT_W  8   shift-amount width (ARM Rs[7:0])
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      engine can accept a request
//  op         in   3      0=LSL 1=LSR 2=ASR 3=ROR 4=RRX; 5-7 treated as LSL
//  amount     in   AMT_W  shift amount (ignored for RRX)
//  operand    in   WIDTH  value to shift (Rm)
//  carry_in   in   1      CPSR C flag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  shifted value, held stable while out_valid
//  carry_out  out  1      shifter carry-out, held stable while out_valid
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid=0, result=0, carry_out=0, busy=0. Reset mid-operation discards the request.
//  - FSM: IDLE -> (accept) -> SHIFT if rem>0, else DONE; SHIFT -> SHIFT while rem>STEP;
//    SHIFT -> DONE on the edge performing the final step; DONE -> IDLE on out_valid&&out_ready.
//  - Accept = in_valid && in_ready; in_ready = (state==IDLE). Inputs are latched on the accept edge.
//  - Each SHIFT edge shifts by min(rem,STEP), rem -= step; carry = last bit shifted out (ROR: bit rotated to MSB).
//  - Latency: out_valid rises 1+ceil(rem/STEP) edges after accept; rem=0 -> 1 edge.
//  - rem on accept: LSL/LSR/ASR -> min(amount,WIDTH); ROR -> amount mod WIDTH; RRX -> 0.
//  - amount==0 (any op but RRX): result=operand, carry_out=carry_in.
//  - LSL/LSR amount==WIDTH: result 0, carry = bit0 (LSL) / bit WIDTH-1 (LSR). amount>WIDTH: result 0, carry 0.
//  - ASR amount>=WIDTH: result all sign bits, carry = sign.
//  - ROR amount nonzero multiple of WIDTH: result=operand, carry = bit WIDTH-1.
//  - RRX: result={carry_in, operand[WIDTH-1:1]}, carry=operand[0].
//  - out_valid held with stable result/carry_out until out_ready; out_ready ignored when out_valid=0.
// CONFIGURATION
//  SHIFT_ENGINE_BYPASS_EN defined: in_ready also high in DONE when out_ready=1; a request accepted on
//   the output-handshake edge loads directly (no IDLE bubble), giving 1 result/cycle for rem=0 streams.
//  Undefined: DONE always returns to IDLE; one bubble cycle between back-to-back requests.
// STRUCTURE
//  shift_pkg: op encodings (OP_LSL..OP_RRX), state enum (IDLE/SHIFT/DONE), helper for rem computation.
//  Sub-module shift_step: combinational shift of WIDTH bits by 0..STEP for a given op, outputs value and carry.
//  shift_engine holds the FSM, rem counter, special-case flags and output registers.
// TESTING
//  1. LSL 0x0000_00FF by 4, STEP=8 -> result 0x0000_0FF0, carry 0, out_valid 2 edges after accept.
//  2. LSR 0x8000_0001 by 32 -> 0, carry 1; by 33 -> 0, carry 0; LSL 0x1 by 32 -> 0, carry 1.
//  3. ASR 0x8000_0000 by 40 -> 0xFFFF_FFFF, carry 1; ASR by 0 with carry_in=1 -> unchanged, carry 1.
//  4. ROR 0x0000_0001 by 36 -> 0x1000_0000, carry 0; ROR 0x8000_0000 by 64 -> unchanged, carry 1; RRX 0x3, C=1 -> 0x8000_0001, carry 1.
//  5. out_ready held low 5 cycles in DONE -> result/carry stable, in_ready per config; assert rst mid-SHIFT -> IDLE, out_valid 0 next cycle.
//  6. Back-to-back amount-0 requests with out_ready=1: BYPASS_EN -> one result/cycle; without -> one per 2 cycles.

Source files
------------

// File: rtl/shift_engine_pkg.sv
// Shared encodings for the operand-2 shift engine: op codes, FSM states and
// the helper that turns a raw request into a remaining-bit count.
package shift_engine_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_RRX = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Reserved encodings 5-7 behave as LSL.
    function automatic op_e norm_op(input logic [2:0] raw);
        return (raw > 3'd4) ? OP_LSL : op_e'(raw);
    endfunction

    // Bit positions still to be shifted after accept. LSL/LSR/ASR saturate at
    // width; a WIDTH-bit walk already yields the ARM result for amount==width.
    function automatic int unsigned calc_rem(input op_e op, input int unsigned amt,
                                             input int unsigned width);
        case (op)
            OP_RRX:  return 0;
            OP_ROR:  return amt % width;
            default: return (amt > width) ? width : amt;
        endcase
    endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Request/response bundle of the shift engine; master issues requests and
// consumes results, slave is the engine.
interface shift_engine_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] operand;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, op, amount, operand, carry_in, out_ready,
        input  in_ready, out_valid, result, carry_out, busy
    );

    modport slave (
        input  in_valid, op, amount, operand, carry_in, out_ready,
        output in_ready, out_valid, result, carry_out, busy
    );
endinterface

// File: rtl/shift_engine_step.sv
// Combinational single-step shifter: shifts WIDTH bits by 0..STEP positions
// and reports the last bit shifted out (ROR: the bit landing in the MSB).
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 4
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic [SW-1:0]    n_i,
    output logic [WIDTH-1:0] val_o,
    output logic             carry_o
);

    // Double-width window: the bits falling off one end land in the other half,
    // which makes the carry a fixed bit position for every amount.
    logic [2*WIDTH-1:0] ext;

    always_comb begin
        ext     = '0;
        val_o   = val_i;
        carry_o = 1'b0;
        case (op_i)
            OP_LSR: begin
                ext     = {val_i, {WIDTH{1'b0}}} >> n_i;
                val_o   = ext[2*WIDTH-1:WIDTH];
                carry_o = ext[WIDTH-1];
            end
            OP_ASR: begin
                ext     = $signed({val_i, {WIDTH{1'b0}}}) >>> n_i;
                val_o   = ext[2*WIDTH-1:WIDTH];
                carry_o = ext[WIDTH-1];
            end
            OP_ROR: begin
                ext     = {val_i, val_i} >> n_i;
                val_o   = ext[WIDTH-1:0];
                carry_o = ext[WIDTH-1];
            end
            default: begin
                ext     = {{WIDTH{1'b0}}, val_i} << n_i;
                val_o   = ext[WIDTH-1:0];
                carry_o = ext[WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle ARM operand-2 shifter, STEP bits per cycle, valid/ready on both sides.
// Define SHIFT_ENGINE_BYPASS_EN to accept a new request on the output-handshake edge.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int AMT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    shift_engine_if.slave  bus
);

    localparam int RW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(STEP + 1);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    state_e           state_q;
    op_e              op_q;
    logic [RW-1:0]    rem_q;
    logic [WIDTH-1:0] val_q;
    logic             carry_q;
    logic             zc_q;
    logic             vld_q;

    logic             in_ready;
    logic             accept;
    op_e              op_n;
    logic [31:0]      amt32;
    logic [RW-1:0]    rem_d;
    logic [WIDTH-1:0] val_d;
    logic             carry_d;
    logic             zc_d;
    logic [SW-1:0]    step_n;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

`ifdef SHIFT_ENGINE_BYPASS_EN
    assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif
    assign accept = bus.in_valid && in_ready;

    // Load-time values; rem==0 requests are fully resolved here.
    always_comb begin
        op_n    = norm_op(bus.op);
        amt32   = 32'(bus.amount);
        rem_d   = RW'(calc_rem(op_n, amt32, WIDTH));
        val_d   = bus.operand;
        carry_d = bus.carry_in;
        zc_d    = (op_n == OP_LSL || op_n == OP_LSR) && (amt32 > WIDTH);
        if (op_n == OP_RRX) begin
            val_d   = {bus.carry_in, bus.operand[WIDTH-1:1]};
            carry_d = bus.operand[0];
        end else if (op_n == OP_ROR && rem_d == '0 && amt32 != 32'd0) begin
            carry_d = bus.operand[WIDTH-1];
        end
    end

    assign step_n = (rem_q > STEP_R) ? SW'(STEP) : SW'(rem_q);

    shift_step #(.WIDTH(WIDTH), .SW(SW)) u_step (
        .op_i   (op_q),
        .val_i  (val_q),
        .n_i    (step_n),
        .val_o  (step_val),
        .carry_o(step_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_LSL;
            rem_q   <= '0;
            val_q   <= '0;
            carry_q <= 1'b0;
            zc_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= op_n;
            rem_q   <= rem_d;
            val_q   <= val_d;
            carry_q <= carry_d;
            zc_q    <= zc_d;
            state_q <= (rem_d == '0) ? DONE : SHIFT;
            vld_q   <= (rem_d == '0);
        end else begin
            case (state_q)
                SHIFT: begin
                    val_q <= step_val;
                    rem_q <= rem_q - RW'(step_n);
                    if (rem_q <= STEP_R) begin
                        // Shifts past the width clear the carry despite the walk.
                        carry_q <= zc_q ? 1'b0 : step_c;
                        state_q <= DONE;
                        vld_q   <= 1'b1;
                    end else begin
                        carry_q <= step_c;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_q;
    assign bus.result    = val_q;
    assign bus.carry_out = carry_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine: directed ARM corner cases, random traffic
// with random backpressure, output hold, mid-shift reset and throughput.
module tb_shift_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_engine_if #(.WIDTH(32), .AMT_W(8)) bus ();
    shift_engine #(.WIDTH(32), .STEP(8), .AMT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   last_acc = 0;
    bit   fresh = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: ARM operand-2 rules written as a direct case analysis.
    task automatic ref_shift(input logic [2:0] op, input int unsigned amt, input logic [31:0] x,
                             input logic cin, output logic [31:0] r, output logic c);
        int unsigned k;
        r = x;
        c = cin;
        case (op)
            3'd4: begin r = {cin, x[31:1]}; c = x[0]; end
            3'd1: begin
                if (amt >= 1 && amt < 32) begin r = x >> amt; c = x[amt-1]; end
                else if (amt == 32) begin r = 0; c = x[31]; end
                else if (amt > 32) begin r = 0; c = 0; end
            end
            3'd2: begin
                if (amt >= 32) begin r = {32{x[31]}}; c = x[31]; end
                else if (amt >= 1) begin r = $signed(x) >>> amt; c = x[amt-1]; end
            end
            3'd3: begin
                k = amt % 32;
                if (amt != 0 && k == 0) c = x[31];
                else if (k != 0) begin r = (x >> k) | (x << (32 - k)); c = r[31]; end
            end
            default: begin
                if (amt >= 1 && amt < 32) begin r = x << amt; c = x[32-amt]; end
                else if (amt == 32) begin r = 0; c = x[0]; end
                else if (amt > 32) begin r = 0; c = 0; end
            end
        endcase
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] amt, input logic [31:0] x,
                        input logic cin, input logic [31:0] er, input logic ec);
        exp_t e;
        int   rem;
        int   n;
        @(negedge clk);
        #2;
        bus.in_valid = 1'b1; bus.op = op; bus.amount = amt; bus.operand = x; bus.carry_in = cin;
        n = 0;
        forever begin
            #2;
            if (bus.in_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout actual=%0d required=<200 cycles", n);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #2;
        end
        rem = (op == 3'd4) ? 0 : (op == 3'd3) ? int'(amt) % 32 : (amt > 32 ? 32 : int'(amt));
        e.res = er; e.c = ec; e.lat = 1 + (rem + 7) / 8; e.acc = cyc;
        sbq.push_back(e);
        last_acc = cyc;
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.busy !== 1'b0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", sbq.size());
        end
    endtask

    // Monitor: pops on each new result, checks hold while stalled, drives out_ready.
    initial begin : monitor
        logic [31:0] held_r;
        logic        held_c;
        exp_t        e;
        held_r = '0;
        held_c = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (fresh) begin
                    if (sbq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out actual=%0h required=none", bus.result);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", 64'(bus.result), 64'(e.res));
                        chk("carry", 64'(bus.carry_out), 64'(e.c));
                        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    held_r = bus.result;
                    held_c = bus.carry_out;
                    fresh = 1'b0;
                end else begin
                    chk("hold_result", 64'(bus.result), 64'(held_r));
                    chk("hold_carry", 64'(bus.carry_out), 64'(held_c));
                end
            end
            case (rdy_mode)
                1:       bus.out_ready = 1'b1;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 99) < 70);
            endcase
            #3;
            if (bus.out_valid === 1'b1 && bus.out_ready) fresh = 1'b1;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  amt;
        logic [31:0] x;
        logic        cin;
        logic [31:0] er;
        logic        ec;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'd0, 8'd4,  32'h0000_00FF, 1'b0, 32'h0000_0FF0, 1'b0},
        '{3'd1, 8'd32, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1},
        '{3'd1, 8'd33, 32'h8000_0001, 1'b1, 32'h0000_0000, 1'b0},
        '{3'd0, 8'd32, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1},
        '{3'd2, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1},
        '{3'd2, 8'd0,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1},
        '{3'd3, 8'd36, 32'h0000_0001, 1'b1, 32'h1000_0000, 1'b0},
        '{3'd3, 8'd64, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1},
        '{3'd4, 8'd9,  32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1},
        '{3'd6, 8'd1,  32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0}
    };

    initial begin : main
        logic [2:0]  op;
        logic [7:0]  amt;
        logic [31:0] x, er;
        logic        cin, ec;
        int          first_acc, n;

        bus.in_valid = 1'b0; bus.op = '0; bus.amount = '0; bus.operand = '0; bus.carry_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_carry", 64'(bus.carry_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        rdy_mode = 1;
        foreach (vecs[i]) send(vecs[i].op, vecs[i].amt, vecs[i].x, vecs[i].cin, vecs[i].er, vecs[i].ec);
        drain();

        rdy_mode = 0;
        repeat (150) begin
            op  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       amt = 8'd0;
                1:       amt = 8'($urandom_range(1, 8));
                2:       amt = 8'($urandom_range(9, 31));
                3:       amt = 8'd32;
                4:       amt = 8'($urandom_range(33, 64));
                default: amt = 8'($urandom_range(0, 255));
            endcase
            x   = $urandom;
            cin = 1'($urandom_range(0, 1));
            ref_shift(op, int'(amt), x, cin, er, ec);
            send(op, amt, x, cin, er, ec);
        end
        rdy_mode = 1;
        drain();

        // Stalled output: result must hold and no new request may be taken.
        rdy_mode = 2;
        send(3'd3, 8'd36, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("stall_valid_rise", 64'(bus.out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        rdy_mode = 1;
        drain();

        // Reset in the middle of a 4-step shift drops the request.
        send(3'd0, 8'd32, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        sbq.delete();
        fresh = 1'b1;
        send(3'd1, 8'd32, 32'h8000_0001, 1'b0, 32'h0, 1'b1);
        drain();

        // Back-to-back amount-0 stream.
        first_acc = 0;
        for (int i = 0; i < 8; i++) begin
            x   = $urandom;
            cin = 1'($urandom_range(0, 1));
            send(3'($urandom_range(0, 3)), 8'd0, x, cin, x, cin);
            if (i == 0) first_acc = last_acc;
        end
`ifdef SHIFT_ENGINE_BYPASS_EN
        chk("throughput", 64'(last_acc - first_acc), 64'd7);
`else
        chk("throughput", 64'(last_acc - first_acc), 64'd14);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
